// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIF FFT rotator sequencer: default sizing,
// sequencer state encoding and derived port widths.
package fft_pkg;

    localparam int LOG2N_DEF   = 4;
    localparam int ROT_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int tw_width(input int log2n);
        return log2n - 1;
    endfunction

    function automatic int stage_width(input int log2n);
        return (log2n > 1) ? $clog2(log2n) : 1;
    endfunction

endpackage

// File: rtl/fft_tw_index.sv
// Combinational twiddle lookup: maps (stage, sample) to the W_N^k index and the
// W^0 bypass flag for the DIF butterfly schedule.
module fft_tw_index
    import fft_pkg::*;
#(
    parameter  int LOG2N = LOG2N_DEF,
    localparam int TW    = tw_width(LOG2N),
    localparam int SW    = stage_width(LOG2N)
) (
    input  logic [SW-1:0]    stage,
    input  logic [LOG2N-1:0] sample,
    output logic [TW-1:0]    tw_idx,
    output logic             tw_bypass
);

    localparam logic [LOG2N-1:0] HALF_BIT = LOG2N'(1) << (LOG2N - 1);
    localparam logic [TW-1:0]    LOW_ONES = '1;

    // The half-span bit of the sample selects the lower butterfly leg; the bits
    // below it give the offset within the group, scaled by 2^stage.
    always_comb begin
        tw_bypass = ~|(sample & (HALF_BIT >> stage));
        if (tw_bypass) begin
            tw_idx = '0;
        end else begin
            tw_idx = (sample[TW-1:0] & (LOW_ONES >> stage)) << stage;
        end
    end

endmodule

// File: rtl/fft_rotator_sched.sv
// Frame sequencer for the shared twiddle rotator: walks LOG2N stages of N beats,
// drains the rotator pipeline between stages and reports frame completion.
module fft_rotator_sched
    import fft_pkg::*;
#(
    parameter  int LOG2N   = LOG2N_DEF,
    parameter  int ROT_LAT = ROT_LAT_DEF,
    localparam int TW      = tw_width(LOG2N),
    localparam int SW      = stage_width(LOG2N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rot_ready,
    output logic             rot_trig,
    output logic             tw_valid,
    output logic [TW-1:0]    tw_idx,
    output logic             tw_bypass,
    output logic [SW-1:0]    stage_idx,
    output logic [LOG2N-1:0] sample_idx,
    output logic             busy,
    output logic             done
);

    localparam int DW = (ROT_LAT > 1) ? $clog2(ROT_LAT) : 1;

    localparam logic [LOG2N-1:0] SAMPLE_LAST = '1;
    localparam logic [SW-1:0]    STAGE_LAST  = SW'(LOG2N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST  = DW'(ROT_LAT - 1);

    state_t            state, state_next;
    logic [SW-1:0]     stage, stage_next;
    logic [LOG2N-1:0]  sample, sample_next;
    logic [DW-1:0]     drain_cnt, drain_next;
    logic [TW-1:0]     idx_next;
    logic              bypass_next;
    logic              run_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            stage     <= '0;
            sample    <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            stage     <= stage_next;
            sample    <= sample_next;
            drain_cnt <= drain_next;
        end
    end

    always_comb begin
        state_next  = state;
        stage_next  = stage;
        sample_next = sample;
        drain_next  = drain_cnt;
        if (abort) begin
            state_next  = IDLE;
            stage_next  = '0;
            sample_next = '0;
            drain_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next  = RUN;
                        stage_next  = '0;
                        sample_next = '0;
                    end
                end
                RUN: begin
                    if (rot_ready) begin
                        if (sample == SAMPLE_LAST) begin
                            state_next = DRAIN;
                            drain_next = '0;
                        end else begin
                            sample_next = sample + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_next = '0;
                        if (stage == STAGE_LAST) begin
                            state_next = DONE;
                        end else begin
                            state_next  = RUN;
                            stage_next  = stage + 1'b1;
                            sample_next = '0;
                        end
                    end else begin
                        drain_next = drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state_next  = IDLE;
                    stage_next  = '0;
                    sample_next = '0;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign run_next = (state_next == RUN);

    fft_tw_index #(
        .LOG2N(LOG2N)
    ) u_tw_index (
        .stage     (stage_next),
        .sample    (sample_next),
        .tw_idx    (idx_next),
        .tw_bypass (bypass_next)
    );

    // Outputs are registered from the next-state view, so they line up with the
    // state they describe while still coming straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rot_trig   <= 1'b0;
            tw_valid   <= 1'b0;
            tw_idx     <= '0;
            tw_bypass  <= 1'b0;
            stage_idx  <= '0;
            sample_idx <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            rot_trig   <= run_next && (state != RUN);
            tw_valid   <= run_next;
            tw_idx     <= run_next ? idx_next : '0;
            tw_bypass  <= run_next && bypass_next;
            stage_idx  <= stage_next;
            sample_idx <= sample_next;
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
        end
    end

endmodule

// File: tb/tb_fft_rotator_sched.sv
// Directed bench for fft_rotator_sched at LOG2N=4, ROT_LAT=3.
module tb_fft_rotator_sched;

    localparam int LOG2N   = 4;
    localparam int ROT_LAT = 3;

    logic       clk = 1'b0;
    logic       rst, start, abort, rot_ready;
    logic       rot_trig, tw_valid, tw_bypass, busy, done;
    logic [2:0] tw_idx;
    logic [1:0] stage_idx;
    logic [3:0] sample_idx;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    fft_rotator_sched #(
        .LOG2N   (LOG2N),
        .ROT_LAT (ROT_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .rot_ready  (rot_ready),
        .rot_trig   (rot_trig),
        .tw_valid   (tw_valid),
        .tw_idx     (tw_idx),
        .tw_bypass  (tw_bypass),
        .stage_idx  (stage_idx),
        .sample_idx (sample_idx),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] outs();
        return {rot_trig, tw_valid, tw_idx, tw_bypass, stage_idx, sample_idx, busy, done};
    endfunction

    // {bypass, k} straight from the DIF rule: half = N>>(s+1), p = c mod 2*half.
    function automatic logic [3:0] exp_tw(input int s, input int c);
        int half, p;
        half = 16 >> (s + 1);
        p    = c % (2 * half);
        if (p < half) return 4'b1000;
        return {1'b0, 3'((p - half) << s)};
    endfunction

    // mode 0: rot_ready always 1; mode 1: ready low on each stage's first beat, then toggling.
    task automatic run_frame(input int mode, input int exp_cycles);
        int n, s_e, c_e, beats, trigs;
        logic prev_valid;
        logic [3:0] e;
        start = 1'b1;
        rot_ready = (mode == 0);
        tick;
        start = 1'b0;
        n = 1; s_e = 0; c_e = 0; beats = 0; trigs = 0; prev_valid = 1'b0;
        while (!done && n < 400) begin
            if (tw_valid) begin
                e = exp_tw(s_e, c_e);
                check("stage_idx", stage_idx, s_e);
                check("sample_idx", sample_idx, c_e);
                check("tw_idx", tw_idx, e[2:0]);
                check("tw_bypass", tw_bypass, e[3]);
                check("rot_trig", rot_trig, !prev_valid);
                if (rot_trig) trigs++;
                if (mode == 1) rot_ready = rot_trig ? 1'b0 : ~rot_ready;
                if (rot_ready) begin
                    beats++;
                    if (c_e == 15) begin
                        c_e = 0;
                        s_e++;
                    end else begin
                        c_e++;
                    end
                end
            end
            prev_valid = tw_valid;
            tick;
            n++;
        end
        check("done_cycle", n, exp_cycles);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 1);
        check("trig_count", trigs, 4);
        check("beat_count", beats, 64);
        tick;
        check("busy_after_done", busy, 0);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;

        // 1: reset held 8 cycles with a start pulse inside it
        rst = 1'b1; start = 1'b0; abort = 1'b0; rot_ready = 1'b0;
        repeat (3) @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("outs_in_reset", outs(), 14'd0);
        @(negedge clk);
        rst = 1'b0;
        tick;
        check("outs_after_reset", outs(), 14'd0);
        tick;
        check("start_in_reset_ignored", outs(), 14'd0);

        // 2: full frame, rotator always ready
        run_frame(0, 77);

        // 3: rotator stalls every other cycle
        run_frame(1, 141);
        rot_ready = 1'b1;

        // 4: abort at s2,c5 then a clean frame
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!(tw_valid && stage_idx == 2 && sample_idx == 5) && n < 200) begin
            tick;
            n++;
        end
        check("abort_point_reached", n < 200, 1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", tw_valid, 0);
        check("abort_done", done, 0);
        check("abort_counters", {stage_idx, sample_idx}, 0);
        seen = 1'b0;
        repeat (20) begin
            tick;
            seen = seen | done | busy;
        end
        check("abort_stays_idle", seen, 0);
        run_frame(0, 77);

        // 5: start held high, back-to-back frames
        start = 1'b1;
        rot_ready = 1'b1;
        n = 0;
        while (!done && n < 200) begin
            tick;
            n++;
        end
        check("b2b_first_done", n, 77);
        tick;
        check("b2b_idle_gap_busy", busy, 0);
        check("b2b_idle_gap_valid", tw_valid, 0);
        tick;
        check("b2b_restart", {busy, tw_valid, rot_trig, stage_idx, sample_idx}, {3'b111, 6'd0});
        n = 1;
        while (!done && n < 200) begin
            tick;
            n++;
        end
        check("b2b_second_done", n, 77);
        start = 1'b0;
        tick;
        check("b2b_end_idle", busy, 0);
        tick;
        check("b2b_no_third", busy, 0);

        // 6: asynchronous reset in the middle of a drain
        start = 1'b1;
        tick;
        start = 1'b0;
        n = 0;
        while (!(busy && !tw_valid) && n < 200) begin
            tick;
            n++;
        end
        check("drain_reached", n < 200, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_outs", outs(), 14'd0);
        #2;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick;
            seen = seen | busy | tw_valid | done;
        end
        check("no_resume_without_start", seen, 0);
        run_frame(0, 77);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
